// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXECUTE -> [MEM] -> WB.
// Owns PC, instruction register and retired counter; gates decoder write enables.
module cpu_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [31:0] pc,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  input  logic        dec_reg_wren,
  input  logic        dec_ram_wren,
  input  logic        dec_reg_write_data_src,
  input  logic [1:0]  dec_next_pc_src,
  input  logic        alu_zero,
  input  logic [31:0] branch_target,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        reg_wren,
  output logic        load_data_en,
  output logic [31:0] retired,
  output logic        fault,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  // The counter holds the number of cycles already waited; the request whose
  // last allowed cycle sees no ready faults on the following edge.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      cur_state;
  state_t      nxt_state;
  logic [31:0] next_pc;
  logic [31:0] next_pc_d;
  logic [31:0] pc_plus4;
  logic [7:0]  tmo_cnt;
  logic        tmo_hit;
  logic        mem_needed;

  assign pc_plus4   = pc + 32'd4;
  assign tmo_hit    = (tmo_cnt == TMO_LAST);
  assign mem_needed = dec_ram_wren | (dec_reg_wren & dec_reg_write_data_src);
  assign state      = cur_state;

  always_comb begin
    next_pc_d = pc_plus4;
    case (dec_next_pc_src)
      2'd0: next_pc_d = pc_plus4;
      2'd1: next_pc_d = branch_target;
      2'd2: next_pc_d = alu_zero  ? branch_target : pc_plus4;
      2'd3: next_pc_d = !alu_zero ? branch_target : pc_plus4;
      default: next_pc_d = pc_plus4;
    endcase
  end

  always_comb begin
    nxt_state    = cur_state;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    reg_wren     = 1'b0;
    load_data_en = 1'b0;
    fault        = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (run) nxt_state = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready)   nxt_state = S_DECODE;
        else if (tmo_hit) nxt_state = S_FAULT;
      end
      S_DECODE: begin
        nxt_state = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (next_pc_d[1:0] != 2'b00) nxt_state = S_FAULT;
        else if (mem_needed)         nxt_state = S_MEM;
        else                         nxt_state = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_ram_wren;
        if (dmem_ready) begin
          load_data_en = dec_reg_write_data_src & ~dec_ram_wren;
          nxt_state    = S_WB;
        end else if (tmo_hit) begin
          nxt_state = S_FAULT;
        end
      end
      S_WB: begin
        reg_wren  = dec_reg_wren;
        nxt_state = run ? S_FETCH : S_IDLE;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: nxt_state = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state   <= S_IDLE;
      pc          <= RESET_PC;
      next_pc     <= RESET_PC;
      instruction <= '0;
      retired     <= '0;
      tmo_cnt     <= '0;
    end else begin
      cur_state <= nxt_state;
      if (nxt_state != cur_state)
        tmo_cnt <= '0;
      else if (cur_state == S_FETCH || cur_state == S_MEM)
        tmo_cnt <= tmo_cnt + 8'd1;
      if (cur_state == S_FETCH && imem_ready)
        instruction <= imem_rdata;
      if (cur_state == S_EXECUTE)
        next_pc <= next_pc_d;
      if (cur_state == S_WB) begin
        pc      <= next_pc;
        retired <= retired + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: per-instruction expectations are queued
// when stimulus is issued and retired against the DUT at WB or FAULT.
module tb_cpu_sequencer;

  localparam int          TB_TIMEOUT = 6;
  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam logic [2:0]  ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_EXEC = 3'd3,
                          ST_MEM = 3'd4, ST_WB = 3'd5, ST_FAULT = 3'd6;

  logic        clk = 1'b0;
  logic        rst, run;
  logic [31:0] pc, instruction, retired, imem_rdata, branch_target;
  logic        imem_req, imem_ready, dec_reg_wren, dec_ram_wren, dec_reg_write_data_src;
  logic [1:0]  dec_next_pc_src;
  logic        alu_zero, dmem_req, dmem_we, dmem_ready, reg_wren, load_data_en, fault;
  logic [2:0]  state;

  cpu_sequencer #(.RESET_PC(TB_RESET_PC), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .run(run), .pc(pc), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instruction(instruction),
    .dec_reg_wren(dec_reg_wren), .dec_ram_wren(dec_ram_wren),
    .dec_reg_write_data_src(dec_reg_write_data_src), .dec_next_pc_src(dec_next_pc_src),
    .alu_zero(alu_zero), .branch_target(branch_target), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_ready(dmem_ready), .reg_wren(reg_wren),
    .load_data_en(load_data_en), .retired(retired), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] insn;
    int          cycles;
    int          fetch_cyc;
    int          mem_cyc;
    int          we_cyc;
    int          ld_cyc;
    int          rw_cyc;
    bit          faults;
    bit          stops;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_retired;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_npc(input logic [31:0] cur_pc, input logic [1:0] src,
                                            input logic az, input logic [31:0] tgt);
    logic [31:0] seq;
    seq = cur_pc + 32'd4;
    case (src)
      2'd1:    return tgt;
      2'd2:    return az ? tgt : seq;
      2'd3:    return az ? seq : tgt;
      default: return seq;
    endcase
  endfunction

  // Entered at a negedge with the DUT in FETCH (first cycle of the instruction).
  task automatic do_instr(input logic [31:0] insn, input logic rw, input logic mw,
                          input logic wsrc, input logic [1:0] src, input logic az,
                          input logic [31:0] tgt, input int iw, input int dw,
                          input bit drop_run);
    exp_t e, g;
    bit   is_mem, done;
    int   cyc, fc, mc, nreq, nwe, nld, nrw;
    is_mem      = mw | (rw & wsrc);
    e.pc        = exp_pc;
    e.insn      = insn;
    e.next_pc   = model_npc(exp_pc, src, az, tgt);
    e.fetch_cyc = iw + 1;
    e.mem_cyc   = 0;
    e.faults    = 1'b1;
    if (iw >= TB_TIMEOUT) begin
      e.cycles    = TB_TIMEOUT;
      e.fetch_cyc = TB_TIMEOUT;
    end else if (e.next_pc[1:0] != 2'b00) begin
      e.cycles = iw + 3;
    end else if (is_mem && dw >= TB_TIMEOUT) begin
      e.cycles  = iw + 3 + TB_TIMEOUT;
      e.mem_cyc = TB_TIMEOUT;
    end else begin
      e.faults  = 1'b0;
      e.mem_cyc = is_mem ? dw + 1 : 0;
      e.cycles  = iw + 4 + e.mem_cyc;
    end
    e.we_cyc = mw ? e.mem_cyc : 0;
    e.ld_cyc = (!e.faults && is_mem && !mw) ? 1 : 0;
    e.rw_cyc = (!e.faults && rw) ? 1 : 0;
    e.stops  = !e.faults && drop_run;
    sb.push_back(e);

    dec_reg_wren = rw; dec_ram_wren = mw; dec_reg_write_data_src = wsrc;
    dec_next_pc_src = src; alu_zero = az; branch_target = tgt;
    cyc = 0; fc = 0; mc = 0; nreq = 0; nwe = 0; nld = 0; nrw = 0; done = 0;
    for (int k = 0; k < 80 && !done; k++) begin
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      if (state == ST_FETCH) begin
        imem_ready = (fc == iw);
        imem_rdata = insn;
        fc++;
      end
      if (state == ST_MEM) begin
        dmem_ready = (mc == dw);
        mc++;
      end
      if (state == ST_EXEC && drop_run) run = 1'b0;
      #1;
      if (state == ST_FAULT || state == ST_WB) begin
        if (state == ST_WB) begin
          nreq += int'(imem_req); nwe += int'(dmem_we);
          nld += int'(load_data_en); nrw += int'(reg_wren);
          cyc++;
        end
        check("sb_size", 32'(sb.size()), 32'd1);
        g = sb.pop_front();
        check("faulted", 32'(state == ST_FAULT), 32'(g.faults));
        check("cycles", 32'(cyc), 32'(g.cycles));
        check("imem_req_cycles", 32'(nreq), 32'(g.fetch_cyc));
        check("dmem_we_cycles", 32'(nwe), 32'(g.we_cyc));
        check("load_data_en_pulses", 32'(nld), 32'(g.ld_cyc));
        if (state == ST_FAULT) begin
          check("fault_pc_frozen", pc, g.pc);
          check("fault_retired", retired, exp_retired);
          check("fault_flag", 32'(fault), 32'd1);
          check("fault_reg_wren", 32'(nrw), 32'd0);
        end else begin
          check("reg_wren_wb", 32'(nrw), 32'(g.rw_cyc));
          check("ir", instruction, g.insn);
          @(negedge clk);
          exp_pc      = g.next_pc;
          exp_retired = exp_retired + 32'd1;
          #1;
          check("pc_commit", pc, exp_pc);
          check("retired", retired, exp_retired);
          check("post_wb_state", 32'(state), g.stops ? 32'(ST_IDLE) : 32'(ST_FETCH));
          check("reg_wren_post_wb", 32'(reg_wren), 32'd0);
        end
        done = 1;
      end else begin
        nreq += int'(imem_req); nwe += int'(dmem_we);
        nld += int'(load_data_en); nrw += int'(reg_wren);
        if (state != ST_IDLE) cyc++;
        @(negedge clk);
      end
    end
    if (!done) check("instr_cycle_budget", 32'd0, 32'd1);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_pc = TB_RESET_PC;
    exp_retired = '0;
    #1;
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_pc", pc, TB_RESET_PC);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_ir", instruction, 32'd0);
    check("rst_reqs", {29'd0, imem_req, dmem_req, reg_wren}, 32'd0);
  endtask

  task automatic resume();
    run = 1'b1;
    @(negedge clk);
    check("resume_fetch", 32'(state), 32'(ST_FETCH));
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; imem_ready = 1'b0; imem_rdata = '0; dmem_ready = 1'b0;
    dec_reg_wren = 1'b0; dec_ram_wren = 1'b0; dec_reg_write_data_src = 1'b0;
    dec_next_pc_src = 2'd0; alu_zero = 1'b0; branch_target = '0;
    exp_pc = TB_RESET_PC; exp_retired = '0;
    @(negedge clk);
    do_reset();
    @(negedge clk);
    check("idle_without_run", 32'(state), 32'(ST_IDLE));
    resume();

    //       insn          rw    mw    wsrc  src   az    tgt            iw  dw  drop
    do_instr(32'h0050_0093, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,         0,  0,  0); // ADDI
    do_instr(32'h0200_0063, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 32'h40,        0,  0,  0); // BEQ taken
    do_instr(32'h0200_0063, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h80,        0,  0,  0); // BEQ not taken
    do_instr(32'h0a00_1063, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 32'h100,       0,  0,  0); // BNE taken
    do_instr(32'h0000_2083, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0,         0,  3,  0); // LW, 3 waits
    do_instr(32'h0010_2023, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,         0,  3,  0); // SW, 3 waits
    do_instr(32'h0020_8133, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'h0,         2,  0,  0); // fetch waits
    do_instr(32'h0031_01b3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, TB_TIMEOUT-1, 0,  0); // last-chance ready
    do_instr(32'h0000_2203, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0,         1, TB_TIMEOUT-1, 0);
    do_instr(32'hffff_f06f, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 32'h200,       0,  0,  0); // JAL
    do_instr(32'h0042_0293, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,         0,  0,  1); // run dropped
    @(negedge clk);
    check("stays_idle", 32'(state), 32'(ST_IDLE));
    check("idle_imem_req", 32'(imem_req), 32'd0);
    resume();

    do_instr(32'h1020_006f, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 32'h102,       0,  0,  0); // misaligned JAL
    @(negedge clk);
    #1;
    check("fault_sticky", 32'(fault), 32'd1);
    check("fault_state", 32'(state), 32'(ST_FAULT));
    check("fault_no_req", {30'd0, imem_req, dmem_req}, 32'd0);
    do_reset();
    resume();

    do_instr(32'h0000_0013, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, TB_TIMEOUT, 0,  0); // imem timeout
    do_reset();
    resume();
    do_instr(32'h0000_0013, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,         0,  0,  0);
    do_instr(32'h0010_2023, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,         0, TB_TIMEOUT, 0); // dmem timeout
    do_reset();
    resume();

    // Reset while a load waits in MEM; the late ready must be ignored.
    dec_reg_wren = 1'b1; dec_ram_wren = 1'b0; dec_reg_write_data_src = 1'b1;
    dec_next_pc_src = 2'd0;
    for (int k = 0; k < 20 && state != ST_MEM; k++) begin
      imem_ready = (state == ST_FETCH);
      @(negedge clk);
    end
    imem_ready = 1'b0;
    check("reached_mem", 32'(state), 32'(ST_MEM));
    @(negedge clk);
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    rst = 1'b0; dmem_ready = 1'b1;
    #1;
    check("mem_rst_state", 32'(state), 32'(ST_IDLE));
    check("mem_rst_dmem_req", 32'(dmem_req), 32'd0);
    check("mem_rst_pc", pc, TB_RESET_PC);
    @(negedge clk);
    #1;
    check("late_ready_state", 32'(state), 32'(ST_IDLE));
    check("late_ready_ld", 32'(load_data_en), 32'd0);
    check("late_ready_retired", retired, 32'd0);
    dmem_ready = 1'b0;
    exp_pc = TB_RESET_PC; exp_retired = '0;
    resume();
    do_instr(32'h0050_0093, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,         0,  0,  0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control FSM that sequences one instruction at a time through fetch, decode, execute, memory and writeback around the combinational instruction decoder and ALUs.
- Owns the PC, the instruction register and the retired-instruction counter.
- Runs valid/ready handshakes to instruction memory and data memory.
- Gates the decoder's register and RAM write enables so each fires exactly once per instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 255, max cycles a memory request may wait for ready before FAULT (counter width 8 bits; legal range 1..255).

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  synchronous active-high reset
run  input  1  1 = execute; 0 = stop at next instruction boundary (IDLE)
pc  output  32  current PC; also instruction-memory address
imem_req  output  1  instruction fetch request
imem_ready  input  1  fetch complete, imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction
instruction  output  32  instruction register, drives decoder
dec_reg_wren  input  1  decoder register write enable
dec_ram_wren  input  1  decoder RAM write enable
dec_reg_write_data_src  input  1  0 = ALU, 1 = RAM (load)
dec_next_pc_src  input  2  0 never branch, 1 always branch, 2 branch if alu_zero, 3 branch if !alu_zero
alu_zero  input  1  rd-ALU result == 0
branch_target  input  32  pc-ALU result
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write strobe, valid with dmem_req
dmem_ready  input  1  data access complete
reg_wren  output  1  gated register file write enable
load_data_en  output  1  one-cycle pulse capturing load data on dmem_ready
retired  output  32  instructions committed, wraps 2^32-1 -> 0
fault  output  1  sticky fault flag
state  output  3  current state (debug)

Behaviour:
- Reset (rst sampled high):
  - next cycle: state = IDLE, pc = RESET_PC, instruction = 0, retired = 0, fault = 0, timeout counter = 0.
  - all request and enable outputs 0.
  - rst overrides any in-flight handshake; a late ready is ignored.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, FAULT=6.
- IDLE: all outputs low. If run = 1, go to FETCH.
- FETCH:
  - imem_req = 1, held with pc stable until imem_ready.
  - On imem_ready: instruction <= imem_rdata, go to DECODE.
- DECODE: one cycle for decoder and register-file read settling. Go to EXECUTE.
- EXECUTE: one cycle. Latch next_pc:
  - src 0: pc+4.
  - src 1: branch_target.
  - src 2: alu_zero ? branch_target : pc+4.
  - src 3: !alu_zero ? branch_target : pc+4.
  - pc+4 wraps modulo 2^32.
- EXECUTE exits, in priority order:
  - next_pc[1:0] != 0: go to FAULT; no writeback, no commit.
  - dec_ram_wren, or (dec_reg_wren and dec_reg_write_data_src = 1): go to MEM.
  - otherwise: go to WB.
- MEM:
  - dmem_req = 1, dmem_we = dec_ram_wren, held until dmem_ready.
  - On dmem_ready: load_data_en = dec_reg_write_data_src & ~dec_ram_wren (same cycle), go to WB.
- WB: one cycle.
  - reg_wren = dec_reg_wren.
  - Commit: pc <= next_pc, retired <= retired + 1.
  - Next state: FETCH if run = 1, else IDLE.
- reg_wren is never high outside WB; dmem_we is never high outside MEM.
- run deasserted mid-instruction: the instruction completes; the stop happens only at WB.
- Timeout:
  - Counter clears on entry to FETCH/MEM and increments each waiting cycle.
  - If it reaches TIMEOUT without ready: go to FAULT.
  - Ready in the same cycle the counter reaches TIMEOUT counts as success.
- FAULT: fault = 1, all requests and enables 0, pc frozen at the faulting instruction. Exit only via rst.
- Latency with zero-wait memory:
  - 4 cycles per ALU/branch/jump instruction.
  - 5 cycles per load/store.
  - Each memory wait cycle adds 1.

Test Plan:
- Reset then run=1, ADDI with imem_ready immediate -> imem_req high 1 cycle at pc=0, reg_wren pulse in cycle 4, pc=4, retired=1.
- BEQ with alu_zero=1, branch_target=0x40 -> pc=0x40 after WB, reg_wren stays 0; repeat with alu_zero=0 -> pc=0x44.
- Load with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, load_data_en one pulse, reg_wren in next cycle; store -> dmem_we=1, reg_wren=0; each takes 8 cycles total.
- JAL with branch_target=0x102 -> FAULT, fault=1, pc unchanged, retired unchanged; rst -> pc=RESET_PC, fault=0.
- imem_ready never asserted -> FAULT exactly TIMEOUT cycles after FETCH entry; ready on the TIMEOUT-th cycle -> proceeds to DECODE normally.
- run dropped during EXECUTE -> instruction commits, state=IDLE; rst asserted during MEM -> IDLE next cycle, dmem_req=0, late dmem_ready ignored.
